sump2_lb_arbiter: RTL

// Shares the single SUMP2 local-bus slave port (ctrl at addr[2]=0, data at addr[2]=1)

---
 rtl/sump2_lb_arbiter_if.sv | 22 ++
 rtl/sump2_lb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sump2_lb_arbiter_if.sv
// Local-bus port bundle shared by the SUMP2 arbiter's upstream masters and its
// downstream slave. "master" is the side that issues wr/rd pulses; "slave" is
// the side that answers them and reports a full holding slot via busy.
interface sump2_lb_arbiter_if;
  logic        lb_wr;
  logic        lb_rd;
  logic [31:0] lb_addr;
  logic [31:0] lb_wr_d;
  logic [31:0] lb_rd_d;
  logic        lb_rd_rdy;
  logic        busy;

  modport master (
    output lb_wr, lb_rd, lb_addr, lb_wr_d,
    input  lb_rd_d, lb_rd_rdy
  );

  modport slave (
    input  lb_wr, lb_rd, lb_addr, lb_wr_d,
    output lb_rd_d, lb_rd_rdy, busy
  );
endinterface

// File: rtl/sump2_lb_arbiter.sv
// Two-master round-robin arbiter in front of the single SUMP2 local-bus slave.
// Each master owns a one-deep holding slot; the FSM replays one held access at
// a time to the slave and returns read data (or ERR_DATA on timeout) to the
// master that issued it.
module sump2_lb_arbiter #(
  parameter int unsigned TIMEOUT_CYC  = 255,
  parameter int unsigned TIMEOUT_BITS = 8,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic              clk_lb,
  input  logic              reset_n,
  sump2_lb_arbiter_if.slave  m0_if,
  sump2_lb_arbiter_if.slave  m1_if,
  sump2_lb_arbiter_if.master s_if,
  output logic              err_timeout,
  output logic              err_drop
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,  // slave write pulse is on the bus this cycle
    ST_WAIT_RD = 2'd2,
    ST_GAP     = 2'd3   // dead cycle; releases the granted slot
  } state_t;

  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(TIMEOUT_CYC);
  localparam logic [TIMEOUT_BITS-1:0] TMO_ONE  = TIMEOUT_BITS'(1);

  // Upstream requests gathered into index-able form (bit/entry N = master N).
  logic [1:0]  req_wr_w;
  logic [1:0]  req_rd_w;
  logic [31:0] req_addr_w  [2];
  logic [31:0] req_wdata_w [2];

  assign req_wr_w       = {m1_if.lb_wr, m0_if.lb_wr};
  assign req_rd_w       = {m1_if.lb_rd, m0_if.lb_rd};
  assign req_addr_w[0]  = m0_if.lb_addr;
  assign req_addr_w[1]  = m1_if.lb_addr;
  assign req_wdata_w[0] = m0_if.lb_wr_d;
  assign req_wdata_w[1] = m1_if.lb_wr_d;

  state_t                  state_q, state_d;
  logic [1:0]              slot_full_q, slot_full_d;
  logic [1:0]              slot_wr_q, slot_wr_d;
  logic [31:0]             slot_addr_q [2];
  logic [31:0]             slot_addr_d [2];
  logic [31:0]             slot_wdata_q [2];
  logic [31:0]             slot_wdata_d [2];
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic                    s_wr_q, s_wr_d;
  logic                    s_rd_q, s_rd_d;
  logic [31:0]             s_addr_q, s_addr_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic [31:0]             rd_data_q [2];
  logic [31:0]             rd_data_d [2];
  logic [1:0]              rd_rdy_q, rd_rdy_d;
  logic                    err_tmo_q, err_tmo_d;
  logic                    err_drop_q, err_drop_d;
  logic                    pick;
  logic [1:0]              free;

  // State register: every output and slot bit is a flop cleared by reset_n.
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      slot_full_q  <= 2'b00;
      slot_wr_q    <= 2'b00;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // m0 wins the first tie
      tmo_q        <= '0;
      s_wr_q       <= 1'b0;
      s_rd_q       <= 1'b0;
      s_addr_q     <= 32'h0000_0000;
      s_wdata_q    <= 32'h0000_0000;
      rd_rdy_q     <= 2'b00;
      err_tmo_q    <= 1'b0;
      err_drop_q   <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        slot_addr_q[n]  <= 32'h0000_0000;
        slot_wdata_q[n] <= 32'h0000_0000;
        rd_data_q[n]    <= 32'h0000_0000;
      end
    end else begin
      state_q      <= state_d;
      slot_full_q  <= slot_full_d;
      slot_wr_q    <= slot_wr_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tmo_q        <= tmo_d;
      s_wr_q       <= s_wr_d;
      s_rd_q       <= s_rd_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      rd_rdy_q     <= rd_rdy_d;
      err_tmo_q    <= err_tmo_d;
      err_drop_q   <= err_drop_d;
      for (int n = 0; n < 2; n++) begin
        slot_addr_q[n]  <= slot_addr_d[n];
        slot_wdata_q[n] <= slot_wdata_d[n];
        rd_data_q[n]    <= rd_data_d[n];
      end
    end
  end

  // Next-state: arbitration FSM, slave replay, read return and slot capture.
  always_comb begin
    state_d      = state_q;
    slot_full_d  = slot_full_q;
    slot_wr_d    = slot_wr_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tmo_d        = tmo_q;
    s_wr_d       = 1'b0;
    s_rd_d       = 1'b0;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    rd_rdy_d     = 2'b00;
    err_tmo_d    = err_tmo_q;
    err_drop_d   = err_drop_q;
    pick         = 1'b0;
    free         = 2'b00;
    for (int n = 0; n < 2; n++) begin
      slot_addr_d[n]  = slot_addr_q[n];
      slot_wdata_d[n] = slot_wdata_q[n];
      rd_data_d[n]    = rd_data_q[n];
    end

    case (state_q)
      ST_IDLE: begin
        if (|slot_full_q) begin
          pick         = (&slot_full_q) ? ~last_grant_q : slot_full_q[1];
          grant_d      = pick;
          last_grant_d = pick;
          s_addr_d     = slot_addr_q[pick];
          s_wdata_d    = slot_wdata_q[pick];
          if (slot_wr_q[pick]) begin
            s_wr_d  = 1'b1;
            state_d = ST_WR;
          end else begin
            s_rd_d  = 1'b1;
            tmo_d   = '0;
            state_d = ST_WAIT_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_GAP;
      end
      ST_WAIT_RD: begin
        // Real data beats the timeout when both land in the same cycle.
        if (s_if.lb_rd_rdy) begin
          rd_data_d[grant_q] = s_if.lb_rd_d;
          rd_rdy_d[grant_q]  = 1'b1;
          state_d            = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          rd_data_d[grant_q] = ERR_DATA;
          rd_rdy_d[grant_q]  = 1'b1;
          err_tmo_d          = 1'b1;
          state_d            = ST_GAP;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_GAP: begin
        free[grant_q] = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request only lands in an empty slot; a slot being freed this cycle
    // still counts as full, so its owner's request is dropped.
    for (int n = 0; n < 2; n++) begin
      if (req_wr_w[n] || req_rd_w[n]) begin
        if (slot_full_q[n]) begin
          err_drop_d = 1'b1;
        end else begin
          slot_full_d[n]  = 1'b1;
          slot_wr_d[n]    = req_wr_w[n];  // wr+rd together is a write
          slot_addr_d[n]  = req_addr_w[n];
          slot_wdata_d[n] = req_wdata_w[n];
        end
      end
      if (free[n]) begin
        slot_full_d[n] = 1'b0;
      end
    end
  end

  assign m0_if.lb_rd_d   = rd_data_q[0];
  assign m0_if.lb_rd_rdy = rd_rdy_q[0];
  assign m0_if.busy      = slot_full_q[0];
  assign m1_if.lb_rd_d   = rd_data_q[1];
  assign m1_if.lb_rd_rdy = rd_rdy_q[1];
  assign m1_if.busy      = slot_full_q[1];
  assign s_if.lb_wr      = s_wr_q;
  assign s_if.lb_rd      = s_rd_q;
  assign s_if.lb_addr    = s_addr_q;
  assign s_if.lb_wr_d    = s_wdata_q;
  assign err_timeout     = err_tmo_q;
  assign err_drop        = err_drop_q;

endmodule
